alu16_seq: RTL and testbench

- Upstream sequencer for the 8-bit ALU. It executes Game Boy 16-bit arithmetic (ADD HL,rr; INC rr; DEC rr; ADD SP,e8) as two back-to-back 8-bit ALU passes: low byte with ALU_ADD, then high byte with ALU_ADC.
- Sits between the control unit / register file and the ALU. It drives the ALU operand, op, flag and size ports, then captures the ALU data and flag results.
- Returns a 16-bit result and the architecturally correct ZNHC flags, with a start/done handshake.

---
 rtl/alu16_seq_pkg.sv | 43 ++++
 rtl/alu16_seq_if.sv | 31 +++
 rtl/alu16_seq.sv | 145 ++++++++++++++
 tb/tb_alu16_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/alu16_seq_pkg.sv
// Shared opcodes, flag indices and state encodings for the 16-bit ALU sequencer.
// Build option ALU16_SEQ_FAST_INCDEC_EN is consumed in alu16_seq.sv.
package alu16_seq_pkg;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_ADC   = 5'd1;
  localparam logic [4:0] ALU_PASS0 = 5'd16;

  localparam logic ALU_SIZE_8  = 1'b0;
  localparam logic ALU_SIZE_16 = 1'b1;

  // Flag vectors are packed ZNHC, MSB first.
  localparam int unsigned F_Z = 3;
  localparam int unsigned F_N = 2;
  localparam int unsigned F_H = 1;
  localparam int unsigned F_C = 0;

  typedef enum logic [1:0] {
    OP16_ADD   = 2'd0,
    OP16_INC   = 2'd1,
    OP16_DEC   = 2'd2,
    OP16_ADDSP = 2'd3
  } op16_e;

  typedef enum logic [1:0] {
    S16_IDLE = 2'd0,
    S16_LOW  = 2'd1,
    S16_HIGH = 2'd2,
    S16_DONE = 2'd3
  } state16_e;

  // Second operand as {b_hi, b_lo}; INC/DEC become +1 / +(-1) through the adder.
  function automatic logic [15:0] b_operand(op16_e op, logic [15:0] b);
    case (op)
      OP16_ADD:   return b;
      OP16_INC:   return 16'h0001;
      OP16_DEC:   return 16'hFFFF;
      OP16_ADDSP: return {{8{b[7]}}, b[7:0]};
      default:    return b;
    endcase
  endfunction

endpackage

// File: rtl/alu16_seq_if.sv
// Bus between control unit / 8-bit ALU (master) and the 16-bit sequencer (slave).
interface alu16_seq_if;
  logic        start;
  logic [1:0]  op16;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [3:0]  flags_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [3:0]  flags_out;
  logic [4:0]  alu_op;
  logic [7:0]  alu_data0;
  logic [7:0]  alu_data1;
  logic [3:0]  alu_flags;
  logic        alu_size;
  logic [7:0]  alu_res;
  logic [3:0]  alu_res_flags;

  modport master (
    output start, op16, a_in, b_in, flags_in, alu_res, alu_res_flags,
    input  busy, done, result, flags_out,
           alu_op, alu_data0, alu_data1, alu_flags, alu_size
  );

  modport slave (
    input  start, op16, a_in, b_in, flags_in, alu_res, alu_res_flags,
    output busy, done, result, flags_out,
           alu_op, alu_data0, alu_data1, alu_flags, alu_size
  );
endinterface

// File: rtl/alu16_seq.sv
// Game Boy 16-bit arithmetic as two 8-bit ALU passes (ADD low, ADC high).
// Define ALU16_SEQ_FAST_INCDEC_EN to run INC/DEC on a local adder in one cycle.
module alu16_seq
  import alu16_seq_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  alu16_seq_if.slave bus
);

  state16_e    state_q;
  op16_e       op_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [3:0]  fl_q;
  logic [7:0]  res_lo_q;
  logic        c_lo_q;
  logic        h_lo_q;
  logic [15:0] result_q;
  logic [3:0]  flags_q;
  logic        busy_q;
  logic        done_q;

  op16_e       op_d;
  logic [15:0] b_d;
  logic [3:0]  flags_d;

  logic [4:0]  alu_op;
  logic [7:0]  alu_data0;
  logic [7:0]  alu_data1;
  logic [3:0]  alu_flags;
  logic        alu_size;

  logic        unused_res_flags;

  assign op_d = op16_e'(bus.op16);
  assign b_d  = b_operand(op_d, bus.b_in);
  assign unused_res_flags = ^{bus.alu_res_flags[F_Z], bus.alu_res_flags[F_N]};

  // Final flags, selected as the high-byte result is captured.
  always_comb begin
    flags_d = fl_q;
    case (op_q)
      OP16_ADD:   flags_d = {fl_q[F_Z], 1'b0, bus.alu_res_flags[F_H], bus.alu_res_flags[F_C]};
      OP16_ADDSP: flags_d = {1'b0, 1'b0, h_lo_q, c_lo_q};
      default:    flags_d = fl_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S16_IDLE;
      op_q     <= OP16_ADD;
      a_q      <= '0;
      b_q      <= '0;
      fl_q     <= '0;
      res_lo_q <= '0;
      c_lo_q   <= 1'b0;
      h_lo_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S16_IDLE: begin
          if (bus.start) begin
            op_q   <= op_d;
            a_q    <= bus.a_in;
            b_q    <= b_d;
            fl_q   <= bus.flags_in;
            busy_q <= 1'b1;
`ifdef ALU16_SEQ_FAST_INCDEC_EN
            if (op_d == OP16_INC || op_d == OP16_DEC) begin
              result_q <= (op_d == OP16_INC) ? bus.a_in + 16'd1 : bus.a_in - 16'd1;
              flags_q  <= bus.flags_in;
              done_q   <= 1'b1;
              state_q  <= S16_DONE;
            end else begin
              state_q <= S16_LOW;
            end
`else
            state_q <= S16_LOW;
`endif
          end
        end
        S16_LOW: begin
          res_lo_q <= bus.alu_res;
          c_lo_q   <= bus.alu_res_flags[F_C];
          h_lo_q   <= bus.alu_res_flags[F_H];
          state_q  <= S16_HIGH;
        end
        S16_HIGH: begin
          result_q <= {bus.alu_res, res_lo_q};
          flags_q  <= flags_d;
          done_q   <= 1'b1;
          state_q  <= S16_DONE;
        end
        S16_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S16_IDLE;
        end
        default: state_q <= S16_IDLE;
      endcase
    end
  end

  // ALU drive is a pure decode of the current pass; idle passes flags through.
  always_comb begin
    alu_op    = ALU_PASS0;
    alu_data0 = '0;
    alu_data1 = '0;
    alu_flags = bus.flags_in;
    alu_size  = ALU_SIZE_8;
    case (state_q)
      S16_LOW: begin
        alu_op    = ALU_ADD;
        alu_data1 = a_q[7:0];
        alu_data0 = b_q[7:0];
        alu_flags = fl_q;
        alu_size  = ALU_SIZE_16;
      end
      S16_HIGH: begin
        alu_op    = ALU_ADC;
        alu_data1 = a_q[15:8];
        alu_data0 = b_q[15:8];
        alu_flags = {fl_q[F_Z], 1'b0, 1'b0, c_lo_q};
        alu_size  = ALU_SIZE_16;
      end
      default: ;
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.flags_out = flags_q;
  assign bus.alu_op    = alu_op;
  assign bus.alu_data0 = alu_data0;
  assign bus.alu_data1 = alu_data1;
  assign bus.alu_flags = alu_flags;
  assign bus.alu_size  = alu_size;

endmodule

// File: tb/tb_alu16_seq.sv
// Directed bench for alu16_seq with a behavioural 8-bit ALU wired back to back.
module tb_alu16_seq;
  import alu16_seq_pkg::*;

`ifdef ALU16_SEQ_FAST_INCDEC_EN
  localparam int unsigned INCDEC_LAT = 1;
`else
  localparam int unsigned INCDEC_LAT = 3;
`endif

  logic clk;
  logic rst_n;
  int unsigned n_vec;
  int unsigned n_err;

  alu16_seq_if bus ();

  alu16_seq dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit ALU: ADD/ADC with nibble and byte carries, PASS0 otherwise.
  logic       alu_cin;
  logic [8:0] alu_sum;
  logic [4:0] alu_hsum;
  always_comb begin
    alu_cin  = (bus.alu_op == ALU_ADC) ? bus.alu_flags[F_C] : 1'b0;
    alu_sum  = {1'b0, bus.alu_data0} + {1'b0, bus.alu_data1} + {8'h00, alu_cin};
    alu_hsum = {1'b0, bus.alu_data0[3:0]} + {1'b0, bus.alu_data1[3:0]} + {4'h0, alu_cin};
    if (bus.alu_op == ALU_ADD || bus.alu_op == ALU_ADC) begin
      bus.alu_res       = alu_sum[7:0];
      bus.alu_res_flags = {alu_sum[7:0] == 8'h00, 1'b0, alu_hsum[4], alu_sum[8]};
    end else begin
      bus.alu_res       = bus.alu_data0;
      bus.alu_res_flags = bus.alu_flags;
    end
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] f, input logic [15:0] er,
                        input logic [3:0] ef, input int unsigned lat);
    int unsigned cyc;
    int unsigned busy_n;
    @(negedge clk);
    bus.start = 1'b1; bus.op16 = op; bus.a_in = a; bus.b_in = b; bus.flags_in = f;
    @(negedge clk);
    // Scramble operands after acceptance: the block must use its latched copies.
    bus.start = 1'b0; bus.op16 = ~op; bus.a_in = 16'hDEAD; bus.b_in = 16'hBEEF; bus.flags_in = ~f;
    cyc = 1;
    busy_n = 0;
    if (lat > 1) begin
      chk({tag, "/lo_op"}, 16'(bus.alu_op), 16'(ALU_ADD));
      chk({tag, "/lo_d1"}, 16'(bus.alu_data1), 16'(a[7:0]));
    end
    while (!bus.done && cyc < 8) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      cyc++;
    end
    if (bus.busy) busy_n++;
    chk({tag, "/latency"}, 16'(cyc), 16'(lat));
    chk({tag, "/busy_cycles"}, 16'(busy_n), 16'(lat));
    chk({tag, "/result"}, bus.result, er);
    chk({tag, "/flags"}, 16'(bus.flags_out), 16'(ef));
    @(negedge clk);
    chk({tag, "/done_pulse"}, 16'(bus.done), 16'h0000);
    chk({tag, "/result_held"}, bus.result, er);
  endtask

  initial begin
    int unsigned n_done;
    int unsigned done_at [2];
    logic [15:0] res_at [2];
    n_vec = 0;
    n_err = 0;
    n_done = 0;
    done_at[0] = 0; done_at[1] = 0;
    res_at[0] = '0; res_at[1] = '0;
    bus.start = 1'b0; bus.op16 = 2'd0; bus.a_in = '0; bus.b_in = '0; bus.flags_in = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst/busy", 16'(bus.busy), 16'h0000);
    chk("rst/done", 16'(bus.done), 16'h0000);
    chk("rst/result", bus.result, 16'h0000);
    chk("rst/flags", 16'(bus.flags_out), 16'h0000);
    chk("rst/alu_op", 16'(bus.alu_op), 16'(ALU_PASS0));
    rst_n = 1'b1;

    run_op("add_h",   2'd0, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010, 3);
    run_op("add_c",   2'd0, 16'h8000, 16'h8000, 4'b0000, 16'h0000, 4'b0001, 3);
    run_op("inc_wrap", 2'd1, 16'hFFFF, 16'h5555, 4'b1010, 16'h0000, 4'b1010, INCDEC_LAT);
    run_op("dec_wrap", 2'd2, 16'h0000, 16'h5555, 4'b0101, 16'hFFFF, 4'b0101, INCDEC_LAT);
    run_op("addsp_p", 2'd3, 16'hFFF8, 16'h7708, 4'b1100, 16'h0000, 4'b0011, 3);
    run_op("addsp_n", 2'd3, 16'h0005, 16'h00FE, 4'b0000, 16'h0003, 4'b0011, 3);

    // start held every cycle: accepted only at index 0 and 4.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done) begin
        if (n_done < 2) begin
          done_at[n_done] = k;
          res_at[n_done] = bus.result;
        end
        n_done++;
      end
      bus.start    = (k < 8);
      bus.op16     = 2'd0;
      bus.a_in     = 16'h0100 * 16'(k) + 16'h0010;
      bus.b_in     = 16'h0001;
      bus.flags_in = 4'b0000;
    end
    bus.start = 1'b0;
    chk("b2b/n_done", 16'(n_done), 16'd2);
    chk("b2b/done0_at", 16'(done_at[0]), 16'd3);
    chk("b2b/done1_at", 16'(done_at[1]), 16'd7);
    chk("b2b/res0", res_at[0], 16'h0011);
    chk("b2b/res1", res_at[1], 16'h0411);

    run_op("pre_rst", 2'd3, 16'h0005, 16'h00FE, 4'b0000, 16'h0003, 4'b0011, 3);
    @(negedge clk);
    bus.start = 1'b1; bus.op16 = 2'd0; bus.a_in = 16'h1234; bus.b_in = 16'h1111; bus.flags_in = 4'b1000;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("mid/in_high", 16'(bus.alu_op), 16'(ALU_ADC));
    chk("mid/busy_pre", 16'(bus.busy), 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    chk("mid/busy", 16'(bus.busy), 16'h0000);
    chk("mid/done", 16'(bus.done), 16'h0000);
    chk("mid/result", bus.result, 16'h0000);
    chk("mid/flags", 16'(bus.flags_out), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) n_done++;
    end
    chk("mid/no_done_after", 16'(n_done), 16'h0000);

    run_op("recover", 2'd0, 16'h1234, 16'h1111, 4'b1000, 16'h2345, 4'b1000, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
